cdc_bus_launcher: RTL and testbench

- Source-domain front end for the multi-cycle bus synchronizer. It accepts words over a valid/ready handshake and drives Unsync_bus and bus_enable toward the destination domain.
- It holds the bus stable and the enable asserted long enough for the destination's enable flop chain to capture the word safely, then releases.
- Two modes:
  - Timed (open-loop): fixed hold and gap lengths.
  - Acknowledged (closed-loop): 4-phase handshake against a synchronized ack level returned from the destination, with a timeout.

---
 rtl/cdc_bus_launcher.sv | 154 +++++++++++++++
 tb/tb_cdc_bus_launcher.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_bus_launcher.sv
// Source-domain launcher for a multi-cycle (enable-qualified) bus synchronizer.
// Accepts a word over valid/ready, drives it onto Unsync_bus with bus_enable high
// long enough for the destination enable chain to capture it, then releases.
// Timed mode uses fixed hold/gap lengths. Acknowledged mode runs a 4-phase
// handshake against a synchronized ack level, with a timeout on each phase.
//
// Ports:
//   CLK, RST          source clock, asynchronous active-low reset
//   in_data/in_valid  word offered for transfer
//   in_ready          block is idle and will accept this cycle
//   ack_sync          destination ack level, already synchronized to CLK
//   err_clr           clears the sticky timeout flag
//   Unsync_bus        registered bus to the destination synchronizer
//   bus_enable        registered enable to the destination synchronizer
//   busy              transfer or gap in progress
//   timeout_err       sticky acknowledged-mode timeout flag
//   sent_count        completed-transfer counter, wraps
module cdc_bus_launcher #(
  parameter int unsigned BUS_WIDTH      = 2,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned USE_ACK        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ack_sync,
  input  logic                 err_clr,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] sent_count
);

  localparam int unsigned CTR_W = 16;

  // Counters run down to zero, so each phase loads its length minus one.
  localparam logic [CTR_W-1:0] HOLD_LOAD = CTR_W'(HOLD_CYCLES - 1);
  localparam logic [CTR_W-1:0] GAP_LOAD  = CTR_W'(GAP_CYCLES - 1);
  localparam logic [CTR_W-1:0] TO_LOAD   = CTR_W'(TIMEOUT_CYCLES - 1);
  localparam logic             ACK_MODE  = (USE_ACK != 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    GAP      = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CTR_W-1:0]     ctr, ctr_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;
  logic                 en_nxt;
  logic                 err_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  // Ready is decoded from the state register alone, so it reads 1 during reset.
  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  // State and registered-output storage.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      ctr         <= '0;
      Unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      timeout_err <= 1'b0;
      sent_count  <= '0;
    end else begin
      state       <= state_nxt;
      ctr         <= ctr_nxt;
      Unsync_bus  <= bus_nxt;
      bus_enable  <= en_nxt;
      timeout_err <= err_nxt;
      sent_count  <= cnt_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    bus_nxt   = Unsync_bus;
    en_nxt    = bus_enable;
    cnt_nxt   = sent_count;
    // Clear first so that a timeout on the same edge overrides it.
    err_nxt   = timeout_err & ~err_clr;

    case (state)
      IDLE: begin
        if (in_valid) begin
          bus_nxt   = in_data;
          en_nxt    = 1'b1;
          state_nxt = HOLD;
          ctr_nxt   = ACK_MODE ? TO_LOAD : HOLD_LOAD;
        end
      end

      HOLD: begin
        if (ACK_MODE) begin
          if (ack_sync) begin
            en_nxt    = 1'b0;
            cnt_nxt   = sent_count + CNT_WIDTH'(1);
            state_nxt = WAIT_LOW;
            ctr_nxt   = TO_LOAD;
          end else if (ctr == '0) begin
            err_nxt   = 1'b1;
            en_nxt    = 1'b0;
            state_nxt = IDLE;
          end else begin
            ctr_nxt = ctr - CTR_W'(1);
          end
        end else begin
          if (ctr == '0) begin
            en_nxt    = 1'b0;
            cnt_nxt   = sent_count + CNT_WIDTH'(1);
            state_nxt = GAP;
            ctr_nxt   = GAP_LOAD;
          end else begin
            ctr_nxt = ctr - CTR_W'(1);
          end
        end
      end

      GAP: begin
        if (ctr == '0) begin
          state_nxt = IDLE;
        end else begin
          ctr_nxt = ctr - CTR_W'(1);
        end
      end

      WAIT_LOW: begin
        if (!ack_sync) begin
          state_nxt = IDLE;
        end else if (ctr == '0) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ctr_nxt = ctr - CTR_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_bus_launcher.sv
// Bench for cdc_bus_launcher: one timed instance (HOLD=8, GAP=4, 2-bit count)
// and one acknowledged instance (TIMEOUT=16). Stimulus pushes the expected
// transfer record; per-instance monitors pop it on each bus_enable pulse.
module tb_cdc_bus_launcher;

  typedef struct {
    logic [1:0] data;
    int         hold;
    int         cnt;
    logic       err;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  rec_t tq[$];
  rec_t aq[$];

  // Timed instance signals
  logic       t_rst = 1'b0, t_valid = 1'b0, t_ack = 1'b0, t_clr = 1'b0;
  logic [1:0] t_data = 2'b00;
  logic       t_ready, t_be, t_busy, t_err;
  logic [1:0] t_bus, t_cnt;

  // Acknowledged instance signals
  logic       a_rst = 1'b0, a_valid = 1'b0, a_ack = 1'b0, a_clr = 1'b0;
  logic [1:0] a_data = 2'b00;
  logic       a_ready, a_be, a_busy, a_err;
  logic [1:0] a_bus;
  logic [7:0] a_cnt;

  cdc_bus_launcher #(
    .BUS_WIDTH(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .USE_ACK(0),
    .TIMEOUT_CYCLES(1024), .CNT_WIDTH(2)
  ) u_timed (
    .CLK(clk), .RST(t_rst), .in_data(t_data), .in_valid(t_valid),
    .in_ready(t_ready), .ack_sync(t_ack), .err_clr(t_clr),
    .Unsync_bus(t_bus), .bus_enable(t_be), .busy(t_busy),
    .timeout_err(t_err), .sent_count(t_cnt)
  );

  cdc_bus_launcher #(
    .BUS_WIDTH(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .USE_ACK(1),
    .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)
  ) u_ack (
    .CLK(clk), .RST(a_rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .ack_sync(a_ack), .err_clr(a_clr),
    .Unsync_bus(a_bus), .bus_enable(a_be), .busy(a_busy),
    .timeout_err(a_err), .sent_count(a_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Timed-instance monitor
  initial begin
    bit   prev;
    int   hold;
    rec_t r;
    prev = 0; hold = 0;
    r = '{data: 2'b00, hold: 0, cnt: 0, err: 1'b0};
    forever begin
      @(negedge clk);
      if (!t_rst) begin
        prev = 0; hold = 0;
      end else begin
        if (t_be && !prev) begin
          chk("t_mon_expected", 32'(tq.size() > 0), 1);
          if (tq.size() > 0) r = tq.pop_front();
          hold = 1;
          chk("t_mon_data", 32'(t_bus), 32'(r.data));
        end else if (t_be) begin
          hold++;
          chk("t_mon_stable", 32'(t_bus), 32'(r.data));
        end else if (prev) begin
          chk("t_mon_hold", 32'(hold), 32'(r.hold));
          chk("t_mon_count", 32'(t_cnt), 32'(r.cnt));
          chk("t_mon_err", 32'(t_err), 32'(r.err));
        end
        prev = t_be;
      end
    end
  end

  // Acknowledged-instance monitor
  initial begin
    bit   prev;
    int   hold;
    rec_t r;
    prev = 0; hold = 0;
    r = '{data: 2'b00, hold: 0, cnt: 0, err: 1'b0};
    forever begin
      @(negedge clk);
      if (!a_rst) begin
        prev = 0; hold = 0;
      end else begin
        if (a_be && !prev) begin
          chk("a_mon_expected", 32'(aq.size() > 0), 1);
          if (aq.size() > 0) r = aq.pop_front();
          hold = 1;
          chk("a_mon_data", 32'(a_bus), 32'(r.data));
        end else if (a_be) begin
          hold++;
          chk("a_mon_stable", 32'(a_bus), 32'(r.data));
        end else if (prev) begin
          chk("a_mon_hold", 32'(hold), 32'(r.hold));
          chk("a_mon_count", 32'(a_cnt), 32'(r.cnt));
          chk("a_mon_err", 32'(a_err), 32'(r.err));
        end
        prev = a_be;
      end
    end
  end

  task automatic t_wait_ready(input string name);
    int n = 0;
    while (!t_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(t_ready), 1);
  endtask

  initial begin
    logic [1:0] vals [3];
    int last;
    vals[0] = 2'b01; vals[1] = 2'b11; vals[2] = 2'b00;
    last = 0;

    // Reset state, including ready during reset
    step(2);
    chk("t_ready_in_reset", 32'(t_ready), 1);
    chk("a_ready_in_reset", 32'(a_ready), 1);
    #2 t_rst = 1'b1; a_rst = 1'b1;
    @(negedge clk);
    chk("t_rst_be", 32'(t_be), 0);
    chk("t_rst_bus", 32'(t_bus), 0);
    chk("t_rst_cnt", 32'(t_cnt), 0);
    chk("t_rst_busy", 32'(t_busy), 0);
    chk("a_rst_err", 32'(a_err), 0);
    chk("a_rst_cnt", 32'(a_cnt), 0);

    // ---------------- Timed: single transfer ----------------
    t_data = 2'b10; t_valid = 1'b1;
    tq.push_back('{data: 2'b10, hold: 8, cnt: 1, err: 1'b0});
    @(negedge clk);
    t_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      chk("t1_ready", 32'(t_ready), 32'(c == 13));
      chk("t1_be", 32'(t_be), 32'(c <= 8));
      chk("t1_bus", 32'(t_bus), 32'(2'b10));
      if (c == 8) chk("t1_cnt_c8", 32'(t_cnt), 0);
      if (c == 9) chk("t1_cnt_c9", 32'(t_cnt), 1);
      if (c < 13) @(negedge clk);
    end

    // ---------------- Timed: back-to-back with in_valid held ----------------
    t_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t_wait_ready("b2b_ready");
      if (k > 0) chk("b2b_period", 32'(cyc - last), 13);
      last = cyc;
      t_data = vals[k];
      tq.push_back('{data: vals[k], hold: 8, cnt: (k + 2) % 4, err: 1'b0});
      @(negedge clk);
      t_data = ~vals[k];
      if (k == 2) t_valid = 1'b0;
    end
    t_wait_ready("b2b_done");
    chk("b2b_cnt_wrap", 32'(t_cnt), 0);

    // Fifth transfer: count wraps 0 -> 1
    t_data = 2'b01; t_valid = 1'b1;
    tq.push_back('{data: 2'b01, hold: 8, cnt: 1, err: 1'b0});
    @(negedge clk);
    t_valid = 1'b0;
    t_wait_ready("t5_done");
    chk("t5_cnt", 32'(t_cnt), 1);

    // ---------------- Timed: reset in the middle of HOLD ----------------
    t_data = 2'b11; t_valid = 1'b1;
    tq.push_back('{data: 2'b11, hold: 8, cnt: 0, err: 1'b0});
    @(negedge clk);
    t_valid = 1'b0;
    step(2);
    chk("rst_pre_be", 32'(t_be), 1);
    #2 t_rst = 1'b0;
    #1;
    chk("rst_async_be", 32'(t_be), 0);
    chk("rst_async_bus", 32'(t_bus), 0);
    chk("rst_async_cnt", 32'(t_cnt), 0);
    chk("rst_async_ready", 32'(t_ready), 1);
    @(negedge clk);
    #2 t_rst = 1'b1;
    @(negedge clk);
    chk("rst_post_ready", 32'(t_ready), 1);
    t_data = 2'b10; t_valid = 1'b1;
    tq.push_back('{data: 2'b10, hold: 8, cnt: 1, err: 1'b0});
    @(negedge clk);
    t_valid = 1'b0;
    chk("rst_post_be", 32'(t_be), 1);
    t_wait_ready("rst_post_done");
    chk("rst_post_cnt", 32'(t_cnt), 1);

    // ---------------- Ack: normal 4-phase handshake ----------------
    a_data = 2'b01; a_valid = 1'b1;
    aq.push_back('{data: 2'b01, hold: 5, cnt: 1, err: 1'b0});
    @(negedge clk);
    a_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("a1_be", 32'(a_be), 32'(c <= 5));
      chk("a1_ready", 32'(a_ready), 32'(c == 10));
      if (c == 5) a_ack = 1'b1;
      if (c == 9) a_ack = 1'b0;
      if (c < 10) @(negedge clk);
    end
    chk("a1_err", 32'(a_err), 0);
    chk("a1_cnt", 32'(a_cnt), 1);

    // ---------------- Ack: ack already high at accept ----------------
    a_ack = 1'b1; a_data = 2'b11; a_valid = 1'b1;
    aq.push_back('{data: 2'b11, hold: 1, cnt: 2, err: 1'b0});
    @(negedge clk);
    a_valid = 1'b0;
    chk("a2_be_c1", 32'(a_be), 1);
    @(negedge clk);
    chk("a2_be_c2", 32'(a_be), 0);
    chk("a2_ready_c2", 32'(a_ready), 0);
    step(2);
    chk("a2_ready_c4", 32'(a_ready), 0);
    a_ack = 1'b0;
    @(negedge clk);
    chk("a2_ready_c5", 32'(a_ready), 1);

    // ---------------- Ack: HOLD timeout, sticky flag, clear ----------------
    a_data = 2'b10; a_valid = 1'b1;
    aq.push_back('{data: 2'b10, hold: 16, cnt: 2, err: 1'b1});
    @(negedge clk);
    a_valid = 1'b0;
    step(15);
    chk("to_be_c16", 32'(a_be), 1);
    chk("to_err_c16", 32'(a_err), 0);
    @(negedge clk);
    chk("to_be_c17", 32'(a_be), 0);
    chk("to_err_c17", 32'(a_err), 1);
    chk("to_ready_c17", 32'(a_ready), 1);
    chk("to_cnt_c17", 32'(a_cnt), 2);
    step(3);
    chk("to_err_sticky", 32'(a_err), 1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("to_err_cleared", 32'(a_err), 0);

    // ---------------- Ack: WAIT_LOW timeout with clear on same edge ----------------
    a_ack = 1'b1; a_data = 2'b01; a_valid = 1'b1;
    aq.push_back('{data: 2'b01, hold: 1, cnt: 3, err: 1'b0});
    @(negedge clk);
    a_valid = 1'b0;
    step(16);
    chk("wl_err_c17", 32'(a_err), 0);
    chk("wl_ready_c17", 32'(a_ready), 0);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("wl_err_setwins", 32'(a_err), 1);
    chk("wl_ready_c18", 32'(a_ready), 1);
    chk("wl_cnt", 32'(a_cnt), 3);
    chk("wl_bus_held", 32'(a_bus), 32'(2'b01));
    a_ack = 1'b0;
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("wl_err_cleared", 32'(a_err), 0);

    step(3);
    chk("t_queue_drained", 32'(tq.size()), 0);
    chk("a_queue_drained", 32'(aq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
